regfile_access_arbiter: RTL

- Shares the single write port and two combinational read ports of the 4-entry x 4-bit register file between two requesters: req 0 (core datapath) and req 1 (debug/loader).
- After reset, first runs an init sequence that writes INIT_VAL to every register.
- Then grants one request per cycle, round-robin, with a valid/ready handshake and registered read responses.

---
 rtl/regfile_access_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/regfile_access_arbiter.sv
// Arbitrates the shared register file ports between the core datapath (req 0) and debug/loader (req 1).
// After reset it first writes INIT_VAL to every register, then serves one request per cycle round-robin.
module regfile_access_arbiter #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr_a,
  input  logic [2*ADDR_W-1:0] req_addr_b,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_data_a,
  output logic [DATA_W-1:0]   rsp_data_b,
  output logic [ADDR_W-1:0]   rf_read_reg1,
  output logic [ADDR_W-1:0]   rf_read_reg2,
  output logic [ADDR_W-1:0]   rf_write_reg,
  output logic [DATA_W-1:0]   rf_write_data,
  output logic                rf_reg_write,
  input  logic [DATA_W-1:0]   rf_read_data1,
  input  logic [DATA_W-1:0]   rf_read_data2,
  output logic                init_done
);

  localparam int NUM_REGS = 2**ADDR_W;

  typedef enum logic {INIT, RUN} stateT;

  stateT             state;
  logic [ADDR_W-1:0] initCnt;
  logic              rrPtr;
  logic [1:0]        grant;
  logic              grantIdx;
  logic              anyGrant;
  logic              grantWe;
  logic [1:0]        readGrant;
  logic [ADDR_W-1:0] grantAddrA;
  logic [ADDR_W-1:0] grantAddrB;
  logic [DATA_W-1:0] grantWdata;

  // On contention rrPtr names the requester that did not win last time
  always_comb begin
    grant = 2'b00;
    if (state == RUN) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rrPtr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready  = grant;
  assign grantIdx   = grant[1];
  assign anyGrant   = |grant;
  assign grantWe    = grantIdx ? req_we[1] : req_we[0];
  assign readGrant  = grant & ~req_we;
  assign grantAddrA = grantIdx ? req_addr_a[2*ADDR_W-1:ADDR_W] : req_addr_a[ADDR_W-1:0];
  assign grantAddrB = grantIdx ? req_addr_b[2*ADDR_W-1:ADDR_W] : req_addr_b[ADDR_W-1:0];
  assign grantWdata = grantIdx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

  always_comb begin
    rf_reg_write  = 1'b0;
    rf_write_reg  = '0;
    rf_write_data = '0;
    rf_read_reg1  = '0;
    rf_read_reg2  = '0;
    if (state == INIT) begin
      rf_reg_write  = 1'b1;
      rf_write_reg  = initCnt;
      rf_write_data = INIT_VAL;
    end else if (anyGrant && grantWe) begin
      rf_reg_write  = 1'b1;
      rf_write_reg  = grantAddrA;
      rf_write_data = grantWdata;
    end else if (anyGrant) begin
      rf_read_reg1 = grantAddrA;
      rf_read_reg2 = grantAddrB;
    end
  end

  // Read data is captured at the grant edge; rsp_data holds until the next read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      initCnt    <= '0;
      rrPtr      <= 1'b0;
      rsp_valid  <= 2'b00;
      rsp_data_a <= '0;
      rsp_data_b <= '0;
      init_done  <= 1'b0;
    end else begin
      rsp_valid <= readGrant;
      if (|readGrant) begin
        rsp_data_a <= rf_read_data1;
        rsp_data_b <= rf_read_data2;
      end
      if (anyGrant) begin
        rrPtr <= ~grantIdx;
      end
      if (state == INIT) begin
        initCnt <= initCnt + 1'b1;
        if (initCnt == ADDR_W'(NUM_REGS - 1)) begin
          state     <= RUN;
          init_done <= 1'b1;
        end
      end
    end
  end

endmodule
